// File: rtl/mips_id_stage_if.sv
// Decode-stage bus: instruction input, register writeback port and the
// decoded slot presented to the ALU with its valid/ready handshake.
interface mips_id_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [XLEN-1:0]  A;
  logic [XLEN-1:0]  B;
  logic [XLEN-1:0]  store_data;
  logic [4:0]       dest;
  logic             dest_wb;
  logic             mem_rd;
  logic             mem_wr;
  logic             branch;
  logic [XLEN-1:0]  branch_off;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, opcode, func_field, A, B, store_data, dest,
           dest_wb, mem_rd, mem_wr, branch, branch_off, illegal, illegal_count
  );

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, opcode, func_field, A, B, store_data, dest,
           dest_wb, mem_rd, mem_wr, branch, branch_off, illegal, illegal_count
  );
endinterface

// File: rtl/mips_id_stage.sv
// MIPS decode / operand-fetch stage: 32x32 register file with write-through
// bypass, decode of ADD/SUB/AND/OR/NOR/SLT/LW/SW/BEQ into one registered slot.
module mips_id_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_id_stage_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [XLEN-1:0]  r_rf [32];

  logic [5:0]       w_op;
  logic [5:0]       w_fn;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [15:0]      w_imm;
  logic [XLEN-1:0]  w_imm_sext;
  logic [XLEN-1:0]  w_rs_val;
  logic [XLEN-1:0]  w_rt_val;
  logic             w_accept;
  logic             w_func_ok;

  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [4:0]       w_dest;
  logic             w_dest_wb;
  logic             w_mem_rd;
  logic             w_mem_wr;
  logic             w_branch;
  logic [XLEN-1:0]  w_branch_off;
  logic             w_illegal;

  logic             r_out_valid;
  logic [5:0]       r_opcode;
  logic [5:0]       r_func_field;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_store_data;
  logic [4:0]       r_dest;
  logic             r_dest_wb;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic             r_branch;
  logic [XLEN-1:0]  r_branch_off;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_count;

  assign w_op       = bus.instr[31:26];
  assign w_rs       = bus.instr[25:21];
  assign w_rt       = bus.instr[20:16];
  assign w_rd       = bus.instr[15:11];
  assign w_imm      = bus.instr[15:0];
  assign w_fn       = bus.instr[5:0];
  assign w_imm_sext = {{(XLEN-16){w_imm[15]}}, w_imm};

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // A writeback landing on the capture edge is forwarded into the operand.
  assign w_rs_val = (w_rs == 5'd0) ? '0 :
                    (bus.wb_en && (bus.wb_addr == w_rs)) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? '0 :
                    (bus.wb_en && (bus.wb_addr == w_rt)) ? bus.wb_data : r_rf[w_rt];

  assign w_func_ok = (w_fn == FN_ADD) || (w_fn == FN_SUB) || (w_fn == FN_AND) ||
                     (w_fn == FN_OR)  || (w_fn == FN_NOR) || (w_fn == FN_SLT);

  always_comb begin
    w_a          = w_rs_val;
    w_b          = w_rt_val;
    w_dest       = w_rd;
    w_dest_wb    = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_branch     = 1'b0;
    w_branch_off = '0;
    w_illegal    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dest_wb = w_func_ok && (w_rd != 5'd0);
        w_illegal = !w_func_ok;
      end
      OP_LW: begin
        w_b       = w_imm_sext;
        w_dest    = w_rt;
        w_dest_wb = (w_rt != 5'd0);
        w_mem_rd  = 1'b1;
      end
      OP_SW: begin
        w_b      = w_imm_sext;
        w_dest   = 5'd0;
        w_mem_wr = 1'b1;
      end
      OP_BEQ: begin
        w_dest       = 5'd0;
        w_branch     = 1'b1;
        w_branch_off = {w_imm_sext[XLEN-3:0], 2'b00};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_opcode     <= '0;
      r_func_field <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_dest       <= '0;
      r_dest_wb    <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_branch     <= 1'b0;
      r_branch_off <= '0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_opcode     <= w_op;
      r_func_field <= w_fn;
      r_a          <= w_a;
      r_b          <= w_b;
      r_store_data <= w_rt_val;
      r_dest       <= w_dest;
      r_dest_wb    <= w_dest_wb;
      r_mem_rd     <= w_mem_rd;
      r_mem_wr     <= w_mem_wr;
      r_branch     <= w_branch;
      r_branch_off <= w_branch_off;
      r_illegal    <= w_illegal;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_count <= '0;
    end else if (w_accept && w_illegal && (r_illegal_count != '1)) begin
      r_illegal_count <= r_illegal_count + CNT_W'(1);
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.opcode        = r_opcode;
  assign bus.func_field    = r_func_field;
  assign bus.A             = r_a;
  assign bus.B             = r_b;
  assign bus.store_data    = r_store_data;
  assign bus.dest          = r_dest;
  assign bus.dest_wb       = r_dest_wb;
  assign bus.mem_rd        = r_mem_rd;
  assign bus.mem_wr        = r_mem_wr;
  assign bus.branch        = r_branch;
  assign bus.branch_off    = r_branch_off;
  assign bus.illegal       = r_illegal;
  assign bus.illegal_count = r_illegal_count;

endmodule

// File: doc/mips_id_stage.md
# mips_id_stage

Instruction-decode / operand-fetch stage that sits directly upstream of the ALU top (`opcode`, `func_field`, `A`, `B` consumer). It holds the 32×32 architectural register file and decodes a 32-bit MIPS instruction into ALU-ready fields and writeback/memory/branch control. It presents the result through one registered output slot with a valid/ready handshake. Supported instructions match the ALU: R-type ADD/SUB/AND/OR/NOR/SLT, LW, SW and BEQ.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `CNT_W`, 16, width of the illegal-instruction counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous reset, active low
- `in_valid`  in  1  `instr` is valid
- `in_ready`  out  1  stage accepts `instr` this cycle
- `instr`  in  32  instruction word
- `wb_en`  in  1  register-file write enable
- `wb_addr`  in  5  write register index
- `wb_data`  in  32  write data
- `out_valid`  out  1  decoded slot holds a valid instruction
- `out_ready`  in  1  downstream consumes the slot
- `opcode`  out  6  `instr[31:26]`
- `func_field`  out  6  `instr[5:0]`
- `A`  out  32  ALU operand A
- `B`  out  32  ALU operand B
- `store_data`  out  32  rt register value (for SW)
- `dest`  out  5  writeback register index
- `dest_wb`  out  1  instruction writes `dest`
- `mem_rd`  out  1  LW
- `mem_wr`  out  1  SW
- `branch`  out  1  BEQ
- `branch_off`  out  32  `sext(imm)<<2` for BEQ; 0 otherwise
- `illegal`  out  1  unsupported opcode or function
- `illegal_count`  out  `CNT_W`  saturating count of accepted illegal instructions

## Operation
- **Field extraction:** rs = `[25:21]`, rt = `[20:16]`, rd = `[15:11]`, imm = `[15:0]`. Sign extension copies bit 15.
- **Register file:** 32 entries. On a clock edge with `wb_en`=1 and `wb_addr`≠0, `rf[wb_addr]` ← `wb_data`. r0 always reads 0 and writes to it are ignored.
- **Write-through bypass:** when an instruction is captured on the same edge as a writeback to rs or rt (nonzero), the captured operand takes `wb_data`.
- **Decode:**
  - R-type (opcode 0x00): A = rf[rs], B = rf[rt], dest = rd. `dest_wb` = 1 when func ∈ {0x20, 0x22, 0x24, 0x25, 0x27, 0x2A} and rd≠0. Any other func sets `illegal` = 1.
  - LW (0x23): A = rf[rs], B = sext(imm), dest = rt, `dest_wb` = (rt≠0), `mem_rd` = 1.
  - SW (0x2B): A = rf[rs], B = sext(imm), `store_data` = rf[rt], `mem_wr` = 1, `dest_wb` = 0.
  - BEQ (0x04): A = rf[rs], B = rf[rt], `branch` = 1, `branch_off` = sext(imm)<<2, `dest_wb` = 0.
  - Any other opcode: `illegal` = 1. All control flags are 0, `dest_wb` = 0, and A/B follow the R-type rule.
- `store_data` = rf[rt] for every instruction.
- **Handshake:**
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - Accept = `in_valid` && `in_ready`. On accept, all decoded outputs are registered and `out_valid` ← 1.
  - On `out_ready` && `out_valid` with no accept, `out_valid` ← 0.
  - While `out_valid` && !`out_ready`, every output holds stable.
- **Operand latching:** operands are latched at accept. Writebacks after accept do not alter a held slot; hazard ordering is the controller's responsibility.
- **Illegal counter:** `illegal_count` increments on each accepted illegal instruction and saturates at 2^`CNT_W`−1.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N shows `out_valid`=1 with its fields after edge N.
- Throughput is 1 instruction per cycle while `out_ready` = 1. Accept and consume in the same cycle is legal; `out_valid` stays 1 with the new contents.
- A register write lands at the edge and is visible to a combinational read in the next cycle. Same-edge reads are covered by the bypass.
- **Reset:** asynchronous assertion on `rst_n` low clears, immediately:
  - the register file;
  - `out_valid` and every decoded output, to 0;
  - `illegal_count`, to 0.
- **Reset mid-operation:** a held instruction is dropped without consumption. While `rst_n`=0, `in_ready` = 1 but no accept occurs. Deassertion is synchronous to `clk`.

## Test plan
- **Reset:** pulse `rst_n` low mid-transfer → `out_valid`=0, `illegal_count`=0, `in_ready`=1. A following ADD r3,r1,r2 yields A=B=0.
- **R-type ADD:** write r1=0x2222, r2=0x1111. Present `instr`=0x00221820 → next cycle `out_valid`=1, `opcode`=0x00, `func_field`=0x20, A=0x2222, B=0x1111, `dest`=3, `dest_wb`=1.
- **LW sign extension:** `instr`=0x8C24FFFC → A=0x2222, B=0xFFFFFFFC, `dest`=4, `dest_wb`=1, `mem_rd`=1.
- **Backpressure:**
  - Hold `out_ready`=0 → `in_ready`=0 and outputs stay stable for 5 cycles. A second `instr` held on the input is not accepted.
  - Raise `out_ready` → the second instruction appears on the following cycle.
- **Bypass with BEQ:** `wb_en`=1, r5=0x5555 on the same edge as `instr`=0x10A50002 → A=B=0x5555, `branch`=1, `branch_off`=0x8, `dest_wb`=0.
- **Illegal and r0:**
  - `instr`=0xFC000000 → `illegal`=1, `dest_wb`=0, `illegal_count` 0→1.
  - Write r0=0xFFFF, then `instr`=0x00000020 → A=B=0, `dest_wb`=0.
